branch_sequencer: RTL

Sequences conditional jumps (jtrue/jfalse) for the processor. It holds the architectural flag register (Z, C, S, O) that the ALU writes. It accepts one branch request at a time from decode and evaluates the condition against the flags. When the branch is taken it loads the PC and flushes the fetch/decode stages for a fixed number of cycles. It sits between the UC/decode stage, the ALU flag outputs and the PC register.

---
 rtl/proc_pkg.sv | 32 +++
 rtl/cond_eval.sv | 41 ++++
 rtl/branch_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_pkg
// Description : Shared definitions for the branch sequencer: flag bit
//               indices, condition-code encodings and the sequencer FSM
//               state type.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

  // Bit positions inside the architectural flag register.
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_O = 3;

  // Condition select encodings. 3'b010 and 3'b011 are intentionally unused.
  localparam logic [2:0] COND_TRUE     = 3'b000;
  localparam logic [2:0] COND_NEG      = 3'b001;
  localparam logic [2:0] COND_CARRY    = 3'b100;
  localparam logic [2:0] COND_ZERO     = 3'b101;
  localparam logic [2:0] COND_NEG_ZERO = 3'b110;
  localparam logic [2:0] COND_OVF      = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_FLUSH = 2'd2
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cond_eval
// Description : Combinational branch condition evaluator. Selects the raw
//               condition from the flags, then applies jtrue/jfalse polarity.
//               Undefined condition codes never produce a taken branch.
// Revision    : 1.0 - initial release
// Ports       : opcode (1 = jtrue, 0 = jfalse), cond (condition select),
//               flags (Z,C,S,O at bits 0..3), taken (branch decision)
// ============================================================================
module cond_eval
  import proc_pkg::*;
(
  input  logic       opcode,
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic w_raw;
  logic w_defined;

  always_comb begin
    w_raw     = 1'b0;
    w_defined = 1'b1;
    case (cond)
      COND_TRUE:     w_raw = 1'b1;
      COND_NEG:      w_raw = flags[FLAG_S];
      COND_CARRY:    w_raw = flags[FLAG_C];
      COND_ZERO:     w_raw = flags[FLAG_Z];
      COND_NEG_ZERO: w_raw = flags[FLAG_S] | flags[FLAG_Z];
      COND_OVF:      w_raw = flags[FLAG_O];
      default:       w_defined = 1'b0;
    endcase
  end

  // Undefined codes are forced not-taken regardless of polarity.
  assign taken = w_defined & (opcode ? w_raw : ~w_raw);

endmodule
`default_nettype wire

// File: rtl/branch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : branch_sequencer
// Description : Conditional jump sequencer. Holds the Z/C/S/O flag register,
//               accepts one branch request at a time, evaluates it, pulses
//               pc_load on a taken branch and then flushes fetch/decode for
//               FLUSH_CYCLES cycles.
// Revision    : 1.0 - initial release
// Config      : FLAG_BYPASS_EN - when defined, a flag write coinciding with
//               EVAL is forwarded to the evaluator instead of costing an
//               extra EVAL cycle.
// Ports       : clk, rst_n (async active-low)
//               alu_flags/flag_we   - flag register write port
//               br_valid/br_ready   - request handshake
//               br_opcode/br_cond/br_target - request fields
//               pc_load/pc_target   - PC load pulse and target
//               flush/stall         - pipeline control
//               taken_count         - saturating taken-branch counter
//               flags_q             - current flag register
// ============================================================================
module branch_sequencer
  import proc_pkg::*;
#(
  parameter int AW           = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    alu_flags,
  input  logic          flag_we,
  input  logic          br_valid,
  output logic          br_ready,
  input  logic          br_opcode,
  input  logic [2:0]    br_cond,
  input  logic [AW-1:0] br_target,
  output logic          pc_load,
  output logic [AW-1:0] pc_target,
  output logic          flush,
  output logic          stall,
  output logic [15:0]   taken_count,
  output logic [3:0]    flags_q
);

  localparam int              CW           = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0]   C_FLUSH_LOAD = CW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  seq_state_t      r_state;
  seq_state_t      w_next_state;
  logic            r_opcode;
  logic [2:0]      r_cond;
  logic [AW-1:0]   r_target;
  logic [3:0]      r_flags;
  logic [15:0]     r_taken_count;
  logic [CW-1:0]   r_flush_cnt;

  logic [3:0]      w_eval_flags;
  logic            w_hold;
  logic            w_taken;
  logic            w_fire;

`ifdef FLAG_BYPASS_EN
  // Forward the flags being written this cycle; no extra EVAL cycle needed.
  assign w_eval_flags = flag_we ? alu_flags : r_flags;
  assign w_hold       = 1'b0;
`else
  // A flag write during EVAL defers the decision until the register settles.
  assign w_eval_flags = r_flags;
  assign w_hold       = flag_we;
`endif

  cond_eval u_cond_eval (
    .opcode (r_opcode),
    .cond   (r_cond),
    .flags  (w_eval_flags),
    .taken  (w_taken)
  );

  assign w_fire = (r_state == ST_EVAL) && !w_hold && w_taken;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (br_valid) w_next_state = ST_EVAL;
      end
      ST_EVAL: begin
        if (w_hold)                          w_next_state = ST_EVAL;
        else if (w_taken && FLUSH_CYCLES > 0) w_next_state = ST_FLUSH;
        else                                 w_next_state = ST_IDLE;
      end
      ST_FLUSH: begin
        if (r_flush_cnt == '0) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    br_ready = (r_state == ST_IDLE);
    stall    = (r_state == ST_EVAL) || (r_state == ST_FLUSH);
    flush    = (r_state == ST_FLUSH);
    pc_load  = w_fire;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode      <= 1'b0;
      r_cond        <= '0;
      r_target      <= '0;
      r_flags       <= '0;
      r_taken_count <= '0;
      r_flush_cnt   <= '0;
    end else begin
      if (flag_we) r_flags <= alu_flags;

      // Request fields are only sampled on the accept cycle.
      if (r_state == ST_IDLE && br_valid) begin
        r_opcode <= br_opcode;
        r_cond   <= br_cond;
        r_target <= br_target;
      end

      if (w_fire && r_taken_count != 16'hFFFF)
        r_taken_count <= r_taken_count + 16'd1;

      // Counter holds remaining flush cycles minus one.
      if (r_state == ST_EVAL && w_next_state == ST_FLUSH)
        r_flush_cnt <= C_FLUSH_LOAD;
      else if (r_state == ST_FLUSH && r_flush_cnt != '0)
        r_flush_cnt <= r_flush_cnt - 1'b1;
    end
  end

  assign pc_target   = r_target;
  assign taken_count = r_taken_count;
  assign flags_q     = r_flags;

endmodule
`default_nettype wire
